// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and constants for the fetch stage
package fetch_pkg;
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  localparam int PC_STEP = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0;
endpackage

// File: rtl/fetch_ifid_register.sv
// ifid_register: IF/ID pipeline register with load, hold and flush controls
module ifid_register
  import fetch_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     flush,
  input  logic [DATA_WIDTH-1:0]    next_instr,
  input  logic [ADDRESS_WIDTH-1:0] next_pc,
  output logic [DATA_WIDTH-1:0]    instr,
  output logic [ADDRESS_WIDTH-1:0] pc,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4,
  output logic                     valid
);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      instr    <= '0;
      pc       <= '0;
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (load) begin
      instr    <= next_instr;
      pc       <= next_pc;
      pc_plus4 <= next_pc + ADDRESS_WIDTH'(PC_STEP);
      valid    <= 1'b1;
    end else if (flush)
      valid <= 1'b0;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: program counter, boot/run/halt control and IF/ID capture
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DEPTH = 256,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = ADDRESS_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [ADDRESS_WIDTH-1:0] pcNew,
  input  logic [DATA_WIDTH-1:0]    instruct,
  input  logic                     stall,
  input  logic                     redirect,
  input  logic [ADDRESS_WIDTH-1:0] redirectTarget,
  output logic [DATA_WIDTH-1:0]    ifidInstr,
  output logic [ADDRESS_WIDTH-1:0] ifidPc,
  output logic [ADDRESS_WIDTH-1:0] ifidPcPlus4,
  output logic                     ifidValid,
  output logic                     alignErr,
  output logic                     rangeErr,
  output logic [31:0]              fetchCount
);
  state_t state, state_nxt;
  logic [ADDRESS_WIDTH-1:0] pc_nxt, target;
  logic load, flush, align_set, range_set, in_range;
  assign target   = {redirectTarget[ADDRESS_WIDTH-1:2], 2'b00};
  assign in_range = (pcNew >> 2) < ADDRESS_WIDTH'(DEPTH);
  always_comb begin
    state_nxt = state;
    pc_nxt    = pcNew;
    load      = 1'b0;
    flush     = 1'b0;
    align_set = 1'b0;
    range_set = 1'b0;
    case (state)
      BOOT: begin
        state_nxt = RUN;
        pc_nxt    = redirect ? target : pcNew;
        align_set = redirect && (redirectTarget[1:0] != 2'b00);
      end
      RUN: begin
        // redirect outranks stall so a flush is never lost behind a hazard
        if (redirect) begin
          pc_nxt    = target;
          flush     = 1'b1;
          align_set = redirectTarget[1:0] != 2'b00;
        end else if (!stall) begin
          load      = in_range;
          flush     = !in_range;
          range_set = !in_range;
          pc_nxt    = in_range ? pcNew + ADDRESS_WIDTH'(PC_STEP) : pcNew;
          state_nxt = in_range ? RUN : HALT;
        end
      end
      HALT: state_nxt = HALT;
      default: state_nxt = BOOT;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= BOOT;
      pcNew      <= RESET_PC;
      alignErr   <= 1'b0;
      rangeErr   <= 1'b0;
      fetchCount <= '0;
    end else begin
      state      <= state_nxt;
      pcNew      <= pc_nxt;
      alignErr   <= alignErr | align_set;
      rangeErr   <= rangeErr | range_set;
      fetchCount <= fetchCount + 32'(load);
    end
  ifid_register #(.DATA_WIDTH(DATA_WIDTH), .ADDRESS_WIDTH(ADDRESS_WIDTH)) u_ifid (
    .clk(clk),
    .rst(rst),
    .load(load),
    .flush(flush),
    .next_instr(instruct),
    .next_pc(pcNew),
    .instr(ifidInstr),
    .pc(ifidPc),
    .pc_plus4(ifidPcPlus4),
    .valid(ifidValid)
  );
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined Harvard core. It owns the program counter, drives the word address into the combinational instruction memory, and captures the returned instruction into the IF/ID pipeline register. It honours stall requests from the hazard unit and taken branch/jump redirects from the execute stage. It detects misaligned redirect targets and fetches beyond the end of instruction memory.

## Interface
- DATA_WIDTH, 32, instruction width
- ADDRESS_WIDTH, 32, PC width
- DEPTH, 256, instruction-memory depth in words; used for range checking
- RESET_PC, 0, PC value loaded by reset
- clk  input  1  core clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- pcNew  output  ADDRESS_WIDTH  current fetch address to instruction memory (byte address)
- instruct  input  DATA_WIDTH  instruction memory read data for pcNew, same cycle
- stall  input  1  hold PC and IF/ID contents
- redirect  input  1  taken branch/jump; overrides stall
- redirectTarget  input  ADDRESS_WIDTH  byte address of redirect destination
- ifidInstr  output  DATA_WIDTH  IF/ID instruction
- ifidPc  output  ADDRESS_WIDTH  PC of ifidInstr
- ifidPcPlus4  output  ADDRESS_WIDTH  ifidPc + 4
- ifidValid  output  1  IF/ID holds a real instruction (0 = bubble)
- alignErr  output  1  sticky: a redirect target had nonzero bits [1:0]
- rangeErr  output  1  sticky: fetch attempted at word index >= DEPTH
- fetchCount  output  32  number of instructions captured into IF/ID, wraps at 2^32

## Operation
- Reset (async, while rst=1): state BOOT, pcNew=RESET_PC, ifidInstr/ifidPc/ifidPcPlus4=0, ifidValid=0, alignErr=0, rangeErr=0, fetchCount=0.
- FSM states: BOOT, RUN, HALT.
- BOOT: lasts one cycle after reset release. No IF/ID capture. Stall is ignored. Redirect is honoured (PC loads the target). Next state is RUN.
- RUN, priority redirect > stall > advance:
  - redirect=1: PC <= {redirectTarget[ADDRESS_WIDTH-1:2],2'b00}; ifidValid <= 0 (flush); other IF/ID fields hold. alignErr <= 1 if redirectTarget[1:0]!=0. fetchCount holds.
  - stall=1, redirect=0: PC and all IF/ID fields hold, including ifidValid. fetchCount holds.
  - advance: if (pcNew>>2) < DEPTH: ifidInstr <= instruct, ifidPc <= pcNew, ifidPcPlus4 <= pcNew+4, ifidValid <= 1, PC <= pcNew+4 (modulo 2^ADDRESS_WIDTH), fetchCount += 1. Otherwise: no capture, ifidValid <= 0, rangeErr <= 1, next state HALT.
- HALT: PC, IF/ID data and fetchCount are frozen; ifidValid=0. Redirect and stall are ignored. Only reset exits HALT.
- The error flags are sticky and are cleared only by reset.
- Arithmetic: PC increments are unsigned. The low two bits of the PC are always 0.

## Timing
- Fetch-to-IF/ID latency: 1 cycle. The instruction at pcNew in cycle N appears on ifidInstr after edge N.
- Redirect asserted in cycle N: pcNew = target after edge N; ifidValid=0 during N+1. The target instruction is valid in IF/ID after edge N+1.
- Redirect and stall in the same cycle: redirect wins, and the flush takes effect.
- Stall held for k cycles: outputs are unchanged for k cycles, with no duplicate or lost instruction.
- rst asserted mid-cycle: outputs take reset values immediately, without waiting for clk.

## Structure
- Shared package fetch_pkg: state enum {BOOT, RUN, HALT}, PC_STEP=4, default RESET_PC.
- One natural sub-module: ifid_register. It holds instr, pc, pcPlus4 and valid, with load, hold and flush controls. The PC/FSM logic stays in fetch_stage.

## Test plan
- Reset, then 4 free-running cycles with instruct = 0x20000000+pc: pcNew goes 0, 0 (BOOT), 4, 8, C. ifidPc 0,4,8 with matching ifidInstr, ifidValid=1 from the first capture, fetchCount=3.
- stall=1 for 3 cycles at pcNew=0x8: pcNew stays 0x8, ifidPc stays 0x4, fetchCount is unchanged. On release, 0x8 is captured exactly once.
- redirect=1, target=0x40, with stall=1 in the same cycle: next pcNew=0x40, ifidValid=0 for one cycle, then ifidPc=0x40 with valid=1.
- redirect target=0x43: pcNew=0x40 and alignErr=1. alignErr is still 1 after 10 further cycles.
- DEPTH=4, free run: after capturing pc=0xC, the fetch at 0x10 sets rangeErr=1 and ifidValid=0. The block enters HALT, and a subsequent redirect to 0x0 is ignored.
- Assert rst asynchronously between clock edges mid-run: all outputs reach reset values before the next edge. After release, BOOT is repeated.
